// File: rtl/instr_exec_seq_if.sv
// Result stream of the execution sequencer: one signed result per executed instruction,
// moved with a valid/ready handshake.
interface instr_exec_seq_if;
  logic               res_valid;
  logic               res_ready;
  logic signed [63:0] res_data;
  logic [4:0]         res_ptr;
  logic [3:0]         res_opc;
  logic               res_err;

  modport master (
    output res_valid, res_data, res_ptr, res_opc, res_err,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_data, res_ptr, res_opc, res_err,
    output res_ready
  );
endinterface

// File: rtl/instr_exec_seq.sv
// Execution sequencer: walks instruction-register locations, executes each stored instruction
// and streams one signed 64-bit result per instruction; DIV/MOD use an iterative divider.
module instr_exec_seq #(
  parameter int unsigned DIV_STEPS = 32
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [4:0]         i_start_ptr,
  input  logic [5:0]         i_count,
  output logic [4:0]         o_read_pointer,
  input  logic [67:0]        i_instruction_word,
  instr_exec_seq_if.master   res_if,
  output logic               o_busy,
  output logic               o_done
);
  localparam int unsigned CntW = $clog2(DIV_STEPS + 1);
  localparam logic [CntW-1:0] LastStep = CntW'(DIV_STEPS - 1);

  typedef enum logic [2:0] {StIdle, StFetch, StExec, StDivide, StOut} state_e;

  state_e             r_state, w_state_d;
  logic [4:0]         r_ptr;
  logic [5:0]         r_remaining;
  logic [3:0]         r_opc;
  logic [31:0]        r_op_a, r_op_b;
  logic signed [63:0] r_res_data;
  logic               r_res_err;
  logic               r_done;
  logic [31:0]        r_div_rem, r_div_quo, r_div_dsor;
  logic [CntW-1:0]    r_div_cnt;
  logic               r_neg_q, r_neg_r, r_is_mod;

  logic               w_start_ok, w_is_div, w_b_zero;
  logic signed [63:0] w_a64, w_b64, w_exec_data;
  logic               w_exec_err;
  logic [31:0]        w_a_mag, w_b_mag;
  logic [32:0]        w_div_shift;
  logic               w_div_ge;
  logic [31:0]        w_div_sub, w_div_rem_n, w_div_quo_n;
  logic [63:0]        w_q64, w_r64, w_div_res;

  assign w_start_ok = i_start && (i_count != 6'd0);
  assign w_is_div   = (r_opc == 4'd6) || (r_opc == 4'd7);
  assign w_b_zero   = (r_op_b == 32'd0);
  assign w_a64      = signed'({{32{r_op_a[31]}}, r_op_a});
  assign w_b64      = signed'({{32{r_op_b[31]}}, r_op_b});
  assign w_a_mag    = r_op_a[31] ? (~r_op_a + 32'd1) : r_op_a;
  assign w_b_mag    = r_op_b[31] ? (~r_op_b + 32'd1) : r_op_b;

  always_comb begin
    w_exec_data = '0;
    w_exec_err  = 1'b0;
    case (r_opc)
      4'd0:       w_exec_data = '0;
      4'd1:       w_exec_data = w_a64;
      4'd2:       w_exec_data = w_b64;
      4'd3:       w_exec_data = w_a64 + w_b64;
      4'd4:       w_exec_data = w_a64 - w_b64;
      4'd5:       w_exec_data = w_a64 * w_b64;
      4'd6, 4'd7: w_exec_err  = w_b_zero;
      default:    w_exec_err  = 1'b1;
    endcase
  end

  // Restoring step on magnitudes; the remainder stays below the divisor, so 32 bits hold it.
  assign w_div_shift = {r_div_rem, r_div_quo[31]};
  assign w_div_ge    = w_div_shift >= {1'b0, r_div_dsor};
  assign w_div_sub   = w_div_shift[31:0] - r_div_dsor;
  assign w_div_rem_n = w_div_ge ? w_div_sub : w_div_shift[31:0];
  assign w_div_quo_n = {r_div_quo[30:0], w_div_ge};
  assign w_q64       = {32'd0, w_div_quo_n};
  assign w_r64       = {32'd0, w_div_rem_n};
  assign w_div_res   = r_is_mod ? (r_neg_r ? -w_r64 : w_r64) : (r_neg_q ? -w_q64 : w_q64);

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) r_state <= StIdle;
    else         r_state <= w_state_d;
  end

  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:   if (w_start_ok) w_state_d = StFetch;
      StFetch:  w_state_d = StExec;
      StExec:   w_state_d = (w_is_div && !w_b_zero) ? StDivide : StOut;
      StDivide: if (r_div_cnt == LastStep) w_state_d = StOut;
      StOut:    if (res_if.res_ready) w_state_d = (r_remaining == 6'd1) ? StIdle : StFetch;
      default:  w_state_d = StIdle;
    endcase
  end

  always_comb begin
    o_busy           = (r_state != StIdle);
    o_done           = r_done;
    o_read_pointer   = r_ptr;
    res_if.res_valid = (r_state == StOut);
    res_if.res_data  = r_res_data;
    res_if.res_ptr   = r_ptr;
    res_if.res_opc   = r_opc;
    res_if.res_err   = r_res_err;
  end

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      r_ptr       <= '0;
      r_remaining <= '0;
      r_opc       <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_res_data  <= '0;
      r_res_err   <= 1'b0;
      r_done      <= 1'b0;
      r_div_rem   <= '0;
      r_div_quo   <= '0;
      r_div_dsor  <= '0;
      r_div_cnt   <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_is_mod    <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        StIdle: if (w_start_ok) begin
          r_ptr       <= i_start_ptr;
          r_remaining <= (i_count > 6'd32) ? 6'd32 : i_count;
        end
        StFetch: begin
          r_opc  <= i_instruction_word[67:64];
          r_op_a <= i_instruction_word[63:32];
          r_op_b <= i_instruction_word[31:0];
        end
        StExec: begin
          r_res_data <= w_exec_data;
          r_res_err  <= w_exec_err;
          if (w_is_div && !w_b_zero) begin
            r_div_rem  <= '0;
            r_div_quo  <= w_a_mag;
            r_div_dsor <= w_b_mag;
            r_div_cnt  <= '0;
            r_neg_q    <= r_op_a[31] ^ r_op_b[31];
            r_neg_r    <= r_op_a[31];
            r_is_mod   <= (r_opc == 4'd7);
          end
        end
        StDivide: begin
          r_div_rem <= w_div_rem_n;
          r_div_quo <= w_div_quo_n;
          r_div_cnt <= r_div_cnt + 1'b1;
          if (r_div_cnt == LastStep) r_res_data <= signed'(w_div_res);
        end
        StOut: if (res_if.res_ready) begin
          r_remaining <= r_remaining - 6'd1;
          if (r_remaining != 6'd1) r_ptr <= r_ptr + 5'd1;
          else                     r_done <= 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: doc/instr_exec_seq.md
# instr_exec_seq

Execution sequencer sitting directly downstream of the instruction register. On a start command it walks a range of instruction-register locations through the register's read port, executes each stored instruction (opcode, operand_a, operand_b), and presents one signed result per instruction on a valid/ready output stream. It contains a control FSM, a wrapping read-pointer counter, a remaining-count counter and a 32-step iterative divider for DIV/MOD.

## Interface

Parameters:
- DIV_STEPS, 32, iterations of the restoring divider; equals the operand width.

Ports:
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- start  in  1  start request, sampled in IDLE only
- start_ptr  in  5  first register location to execute
- count  in  6  number of instructions to execute, legal 1..32
- read_pointer  out  5  register read address, drives instr_register read_pointer
- instruction_word  in  instruction_t  {opc[3:0], op_a signed[31:0], op_b signed[31:0]}, combinational read data for read_pointer
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_data  out  64 signed  result
- res_ptr  out  5  location the result came from
- res_opc  out  4  opcode that produced the result
- res_err  out  1  divide by zero or illegal opcode for this result
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse after the last result is accepted

## Operation

- Opcodes: ZERO=0 → 0; PASSA=1 → op_a; PASSB=2 → op_b; ADD=3 → op_a+op_b; SUB=4 → op_a−op_b; MULT=5 → op_a*op_b; DIV=6 → op_a/op_b; MOD=7 → op_a%op_b.
- Arithmetic is signed. Operands are sign-extended to 64 bits; ADD/SUB/MULT are exact in 64 bits, with no overflow possible.
- DIV truncates toward zero. MOD takes the sign of the dividend. The divider runs on magnitudes and corrects signs at the end.
- op_b=0 with DIV or MOD: res_data=0, res_err=1.
- Opcodes 8..15: res_data=0, res_err=1.
- FSM states:
  - IDLE: start=1 with count≠0 loads ptr←start_ptr, remaining←count, and goes to FETCH. Otherwise stay in IDLE.
  - FETCH: read_pointer=ptr; instruction_word is captured at the end of the cycle; go to EXEC.
  - EXEC: single-cycle ops register their result and go to OUT. DIV/MOD with op_b≠0 load the divider and go to DIVIDE. DIV/MOD with op_b=0 go to OUT with res_err=1.
  - DIVIDE: one iteration per cycle; after DIV_STEPS cycles, register the sign-corrected result and go to OUT.
  - OUT: res_valid=1. When res_ready=1: remaining decrements. If the new remaining≠0, ptr increments and the FSM goes to FETCH. If it is 0, assert done and go to IDLE.
- ptr wraps 31→0. Example: start_ptr=30, count=4 visits locations 30, 31, 0, 1.
- start is ignored while busy=1.
- start with count=0 is ignored and busy stays 0.
- count values above 32 are clamped to 32.

## Timing

- Reset values:
  - read_pointer=0, res_valid=0, res_data=0, res_ptr=0, res_opc=0, res_err=0, busy=0, done=0
  - FSM=IDLE, divider cleared
- Reset asserted mid-operation aborts immediately. The pending result is discarded and no done pulse is issued.
- Latency from the edge that samples start to res_valid high:
  - non-divide ops and error cases: 2 cycles
  - DIV/MOD: 2+DIV_STEPS = 34 cycles
- Handshake rules:
  - Transfer occurs on an edge where res_valid=1 and res_ready=1.
  - res_data, res_ptr, res_opc and res_err are stable while res_valid=1 and res_ready=0.
  - res_valid never depends combinationally on res_ready.
- Back-to-back non-divide instructions with res_ready held high produce one result every 3 cycles (FETCH, EXEC, OUT).
- done pulses in the cycle after the final handshake, coincident with busy=0.
- read_pointer changes only on entry to FETCH and holds otherwise.

## Test plan

- Reset: assert reset asynchronously between edges → all outputs at reset values immediately. Deassert, then start_ptr=0, count=3 over locations holding ADD 5,3 / SUB −15,4 / MULT 7,−2 → results 8, −19, −14 with res_ptr 0, 1, 2, then one done pulse.
- Divide: DIV −15,4 → −3, and MOD −15,4 → −3. Each has res_valid high exactly 34 cycles after the start edge. DIV 15,0 → res_data=0, res_err=1, latency 2.
- Wrap: start_ptr=30, count=4 → read_pointer sequence 30, 31, 0, 1 and res_ptr matches each result.
- Backpressure: hold res_ready=0 for 10 cycles on the first result → outputs held, no FETCH issued. Release → next result follows.
- Ignored starts: start pulsed while busy, and start with count=0 from IDLE → no change to ptr or remaining, and no results.
- Abort: reset asserted in DIVIDE → no res_valid and no done. A new start after release executes normally.
